// File: rtl/adder_check_sequencer.sv
// ----------------------------------------------------------------------------
// adder_check_sequencer
//
// Walks every {Cin,B,A} operand vector through the lookahead and ripple adders
// on the board. Each vector is held for SETTLE_TICKS divider ticks, then both
// adder results are compared against a golden A+B+Cin. The block records how
// many vectors failed and which vector failed first.
//
// Optional build macro: HALT_ON_ERR_EN
//   defined   -> the sweep stops at the first failing vector (vec frozen there)
//   undefined -> the full sweep always runs to the last vector
// ----------------------------------------------------------------------------
module adder_check_sequencer #(
    parameter int SETTLE_TICKS = 2,
    parameter int W            = 4
) (
    input  logic             clock50,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [W-1:0]     sum_l,
    input  logic             cout_l,
    input  logic [W-1:0]     sum_r,
    input  logic             cout_r,
    output logic [W-1:0]     A,
    output logic [W-1:0]     B,
    output logic             Cin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W+1:0]   err_count,
    output logic [2*W:0]     first_err,
    output logic             err_valid
);

    localparam int VW = 2*W + 1;   // vector index width {Cin,B,A}
    localparam int EW = 2*W + 2;   // error counter width, holds a full-sweep count
    localparam int CW = 4;         // settle counter width, SETTLE_TICKS is 1..15

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] VEC_LAST    = {VW{1'b1}};
    localparam logic [VW-1:0] VEC_ONE     = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] ERR_ONE     = {{(EW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reference result for the vector currently on the adder inputs.
    function automatic logic [W:0] golden_sum(input logic [VW-1:0] v);
        golden_sum = {1'b0, v[W-1:0]} + {1'b0, v[2*W-1:W]} + {{W{1'b0}}, v[2*W]};
    endfunction

    // One adder disagrees with the reference (carry and sum as one word).
    function automatic logic adder_mismatch(input logic [W:0] golden,
                                            input logic [W:0] result);
        adder_mismatch = (result != golden);
    endfunction

    state_t         state_r,     state_s;
    logic [VW-1:0]  vec_r,       vec_s;
    logic [CW-1:0]  cnt_r,       cnt_s;
    logic [EW-1:0]  err_count_r, err_count_s;
    logic [VW-1:0]  first_err_r, first_err_s;
    logic           err_valid_r, err_valid_s;
    logic           busy_r,      busy_s;
    logic           done_r,      done_s;
    logic           pass_r,      pass_s;
    logic [W:0]     golden_s;
    logic           fail_s;
    logic           finish_s;

    assign golden_s = golden_sum(vec_r);
    assign fail_s   = adder_mismatch(golden_s, {cout_l, sum_l})
                    | adder_mismatch(golden_s, {cout_r, sum_r});

    // The vector register feeds the adders with the old counter bit mapping.
    assign A         = vec_r[W-1:0];
    assign B         = vec_r[2*W-1:W];
    assign Cin       = vec_r[2*W];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign first_err = first_err_r;
    assign err_valid = err_valid_r;

    // State and datapath registers; reset aborts any sweep and clears results.
    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            vec_r       <= {VW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            err_count_r <= {EW{1'b0}};
            first_err_r <= {VW{1'b0}};
            err_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            vec_r       <= vec_s;
            cnt_r       <= cnt_s;
            err_count_r <= err_count_s;
            first_err_r <= first_err_s;
            err_valid_r <= err_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
        end
    end

    // Next-state and next-register values; start is ungated, everything else waits for tick.
    always_comb begin
        state_s     = state_r;
        vec_s       = vec_r;
        cnt_s       = cnt_r;
        err_count_s = err_count_r;
        first_err_s = first_err_r;
        err_valid_s = err_valid_r;
        busy_s      = busy_r;
        done_s      = done_r;
        pass_s      = pass_r;
        finish_s    = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s     = SETTLE;
                    vec_s       = {VW{1'b0}};
                    cnt_s       = {CW{1'b0}};
                    err_count_s = {EW{1'b0}};
                    first_err_s = {VW{1'b0}};
                    err_valid_s = 1'b0;
                    busy_s      = 1'b1;
                    done_s      = 1'b0;
                    pass_s      = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            SETTLE: begin
                if (tick) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == SETTLE_LAST) begin
                        state_s = CHECK;
                    end else begin
                        state_s = SETTLE;
                    end
                end else begin
                    state_s = SETTLE;
                end
            end

            CHECK: begin
                if (tick) begin
                    if (fail_s) begin
                        err_count_s = err_count_r + ERR_ONE;
                        if (!err_valid_r) begin
                            first_err_s = vec_r;
                            err_valid_s = 1'b1;
                        end else begin
                            first_err_s = first_err_r;
                        end
                    end else begin
                        err_count_s = err_count_r;
                    end
`ifdef HALT_ON_ERR_EN
                    finish_s = fail_s || (vec_r == VEC_LAST);
`else
                    finish_s = (vec_r == VEC_LAST);
`endif
                    // The last vector's result is already folded into err_count_s here.
                    if (finish_s) begin
                        state_s = DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_count_s == {EW{1'b0}});
                    end else begin
                        state_s = SETTLE;
                        vec_s   = vec_r + VEC_ONE;
                        cnt_s   = {CW{1'b0}};
                    end
                end else begin
                    state_s = CHECK;
                end
            end

            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
            end
        endcase
    end

endmodule
